// File: rtl/hex_display_scheduler.sv
// Rotates several debug sources onto six HEX digits, with auto/manual stepping and optional
// freeze snapshot (enabled by defining HEX_SCHED_SNAPSHOT_EN).
module hex_display_scheduler #(
    parameter int unsigned NUM_SRC         = 5,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned DWELL_CYCLES    = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic                      mode_auto,
    input  logic                      key_next_n,
    input  logic                      key_freeze_n,
    output logic [23:0]               disp_data,
    output logic [2:0]                disp_sel,
    output logic                      disp_frozen,
    output logic                      disp_stale
);

    localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {StRunManual, StRunAuto, StFrozen} state_e;

    state_e               state_q, state_d;
    logic [2:0]           sel_q, sel_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [23:0]          data_q;
    logic                 frozen_q, stale_q;
    logic [1:0]           mode_sync_q, next_sync_q;
    logic [DB_W-1:0]      next_cnt_q, next_cnt_d;
    logic                 next_deb_q, next_deb_d, next_p_q;
    logic                 next_p, frz_p, mode_s, capture;
    logic [NUM_SRC-1:0]   vld;
    logic [2:0]           adv_sel;
    logic [23:0]          cur_data;
    logic                 cur_valid;
    logic                 unused_src;

    assign unused_src = ^src_data;
    assign mode_s     = mode_sync_q[1];
    assign next_p     = next_p_q;

    always_comb begin
        next_cnt_d = next_cnt_q;
        next_deb_d = next_deb_q;
        if (next_sync_q[1] == next_deb_q) begin
            next_cnt_d = '0;
        end else if (next_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            next_deb_d = next_sync_q[1];
            next_cnt_d = '0;
        end else begin
            next_cnt_d = next_cnt_q + 1'b1;
        end
    end

`ifdef HEX_SCHED_SNAPSHOT_EN
    logic [1:0]      frz_sync_q;
    logic [DB_W-1:0] frz_cnt_q, frz_cnt_d;
    logic            frz_deb_q, frz_deb_d, frz_p_q;
    logic [23:0]     snap_data_q [NUM_SRC];
    logic [NUM_SRC-1:0] snap_valid_q;

    assign frz_p = frz_p_q;

    always_comb begin
        frz_cnt_d = frz_cnt_q;
        frz_deb_d = frz_deb_q;
        if (frz_sync_q[1] == frz_deb_q) begin
            frz_cnt_d = '0;
        end else if (frz_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            frz_deb_d = frz_sync_q[1];
            frz_cnt_d = '0;
        end else begin
            frz_cnt_d = frz_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frz_sync_q   <= 2'b11;
            frz_cnt_q    <= '0;
            frz_deb_q    <= 1'b1;
            frz_p_q      <= 1'b0;
            snap_valid_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) snap_data_q[i] <= '0;
        end else begin
            frz_sync_q <= {frz_sync_q[0], key_freeze_n};
            frz_cnt_q  <= frz_cnt_d;
            frz_deb_q  <= frz_deb_d;
            frz_p_q    <= frz_deb_q & ~frz_deb_d;
            if (capture) begin
                snap_valid_q <= src_valid;
                for (int i = 0; i < NUM_SRC; i++) snap_data_q[i] <= src_data[i*DATA_W +: 24];
            end
        end
    end
`else
    logic unused_frz;
    assign unused_frz = key_freeze_n;
    assign frz_p      = 1'b0;
`endif

    // Advance target and displayed-source mux; FROZEN reads the snapshot instead of live inputs.
    always_comb begin
        logic       found_hi, found_lo;
        logic [2:0] nxt_hi, nxt_lo;
        vld       = src_valid;
        cur_data  = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_q == 3'(i)) begin
                cur_data  = src_data[i*DATA_W +: 24];
                cur_valid = src_valid[i];
            end
        end
`ifdef HEX_SCHED_SNAPSHOT_EN
        if (state_q == StFrozen) begin
            vld = snap_valid_q;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (sel_q == 3'(i)) begin
                    cur_data  = snap_data_q[i];
                    cur_valid = snap_valid_q[i];
                end
            end
        end
`endif
        found_hi = 1'b0;
        found_lo = 1'b0;
        nxt_hi   = '0;
        nxt_lo   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vld[i]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    nxt_lo   = 3'(i);
                end
                if (!found_hi && (3'(i) > sel_q)) begin
                    found_hi = 1'b1;
                    nxt_hi   = 3'(i);
                end
            end
        end
        adv_sel = found_hi ? nxt_hi : (found_lo ? nxt_lo : sel_q);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        capture = 1'b0;
        unique case (state_q)
            StRunManual: begin
                dwell_d = '0;
                if (frz_p) begin
                    state_d = StFrozen;
                    capture = 1'b1;
                end else if (mode_s) begin
                    state_d = StRunAuto;
                end else if (next_p) begin
                    sel_d = adv_sel;
                end
            end
            StRunAuto: begin
                if (frz_p) begin
                    state_d = StFrozen;
                    capture = 1'b1;
                    dwell_d = '0;
                end else if (!mode_s) begin
                    state_d = StRunManual;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
                    dwell_d = '0;
                    sel_d   = adv_sel;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StFrozen: begin
                dwell_d = '0;
                if (frz_p) begin
                    state_d = mode_s ? StRunAuto : StRunManual;
                end else if (next_p) begin
                    sel_d = adv_sel;
                end
            end
            default: state_d = StRunManual;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRunManual;
            sel_q       <= '0;
            dwell_q     <= '0;
            data_q      <= '0;
            frozen_q    <= 1'b0;
            stale_q     <= 1'b0;
            mode_sync_q <= 2'b00;
            next_sync_q <= 2'b11;
            next_cnt_q  <= '0;
            next_deb_q  <= 1'b1;
            next_p_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            dwell_q     <= dwell_d;
            data_q      <= cur_data;
            frozen_q    <= (state_d == StFrozen);
            stale_q     <= ~cur_valid;
            mode_sync_q <= {mode_sync_q[0], mode_auto};
            next_sync_q <= {next_sync_q[0], key_next_n};
            next_cnt_q  <= next_cnt_d;
            next_deb_q  <= next_deb_d;
            next_p_q    <= next_deb_q & ~next_deb_d;
        end
    end

    assign disp_data   = data_q;
    assign disp_sel    = sel_q;
    assign disp_frozen = frozen_q;
    assign disp_stale  = stale_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed self-checking bench for hex_display_scheduler (NUM_SRC=5, DWELL=4, DEBOUNCE=3).
module tb_hex_display_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [159:0] src_data;
    logic [4:0]   src_valid;
    logic         mode_auto;
    logic         key_next_n;
    logic         key_freeze_n;
    logic [23:0]  disp_data;
    logic [2:0]   disp_sel;
    logic         disp_frozen;
    logic         disp_stale;

    int total = 0;
    int bad   = 0;

    hex_display_scheduler #(
        .NUM_SRC(5),
        .DATA_W(32),
        .DWELL_CYCLES(4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .src_data(src_data),
        .src_valid(src_valid),
        .mode_auto(mode_auto),
        .key_next_n(key_next_n),
        .key_freeze_n(key_freeze_n),
        .disp_data(disp_data),
        .disp_sel(disp_sel),
        .disp_frozen(disp_frozen),
        .disp_stale(disp_stale)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [31:0] base, input bit add_idx);
        for (int i = 0; i < 5; i++) src_data[i*32 +: 32] = add_idx ? base + 32'(i) : base;
    endtask

    task automatic press(input bit nxt, input bit frz, input int low_cycles = 8);
        key_next_n   = ~nxt;
        key_freeze_n = ~frz;
        tick(low_cycles);
        key_next_n   = 1'b1;
        key_freeze_n = 1'b1;
        tick(10);
    endtask

    initial begin
        int waited;
        reset        = 1'b1;
        mode_auto    = 1'b0;
        key_next_n   = 1'b1;
        key_freeze_n = 1'b1;
        src_valid    = '0;
        src_data     = '0;
        tick(3);
        chk("rst_data", 32'(disp_data), 32'h0);
        chk("rst_sel", 32'(disp_sel), 32'h0);
        chk("rst_frozen", 32'(disp_frozen), 32'h0);
        chk("rst_stale", 32'(disp_stale), 32'h0);
        reset = 1'b0;

        // Auto rotation over all-valid sources.
        set_data(32'h00A0_0000, 1'b1);
        src_valid = 5'b11111;
        mode_auto = 1'b1;
        waited = 0;
        while (disp_sel !== 3'd1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("auto_first_step", 32'(disp_sel), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("auto_sel", 32'(disp_sel), 32'(k));
            tick();
            chk("auto_data", 32'(disp_data), 32'h00A0_0000 + 32'(k));
            tick(2);
            chk("auto_hold", 32'(disp_sel), 32'(k));
            tick();
        end
        chk("auto_wrap", 32'(disp_sel), 32'd0);
        mode_auto = 1'b0;
        tick();
        chk("auto_wrap_data", 32'(disp_data), 32'h00A0_0000);

        // Manual stepping over sparse valid set.
        src_valid = 5'b10010;
        tick(6);
        chk("man_hold", 32'(disp_sel), 32'd0);
        press(1'b1, 1'b0);
        chk("man_step1", 32'(disp_sel), 32'd1);
        chk("man_step1_stale", 32'(disp_stale), 32'd0);
        press(1'b1, 1'b0);
        chk("man_step4", 32'(disp_sel), 32'd4);
        chk("man_step4_data", 32'(disp_data), 32'h00A0_0004);
        press(1'b1, 1'b0);
        chk("man_wrap1", 32'(disp_sel), 32'd1);
        press(1'b1, 1'b0, 2);
        chk("man_glitch", 32'(disp_sel), 32'd1);

        // No valid sources.
        reset = 1'b1;
        tick(2);
        reset     = 1'b0;
        src_valid = '0;
        press(1'b1, 1'b0);
        chk("none_sel", 32'(disp_sel), 32'd0);
        chk("none_stale", 32'(disp_stale), 32'd1);

        src_valid = 5'b11111;
        set_data(32'h00A0_0000, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("pre_frz_sel", 32'(disp_sel), 32'd2);
`ifdef HEX_SCHED_SNAPSHOT_EN
        press(1'b0, 1'b1);
        chk("frz_on", 32'(disp_frozen), 32'd1);
        chk("frz_sel", 32'(disp_sel), 32'd2);
        set_data(32'hFFFF_FFFF, 1'b0);
        tick(3);
        chk("frz_snap_data", 32'(disp_data), 32'h00A0_0002);
        press(1'b1, 1'b0);
        chk("frz_next_sel", 32'(disp_sel), 32'd3);
        chk("frz_next_data", 32'(disp_data), 32'h00A0_0003);
        press(1'b0, 1'b1);
        chk("frz_off", 32'(disp_frozen), 32'd0);
        chk("frz_off_live", 32'(disp_data), 32'h00FF_FFFF);
        press(1'b1, 1'b1);
        chk("both_frozen", 32'(disp_frozen), 32'd1);
        chk("both_sel", 32'(disp_sel), 32'd3);
        set_data(32'h00A0_0000, 1'b1);
        reset = 1'b1;
        tick(2);
        chk("mid_rst_data", 32'(disp_data), 32'h0);
        chk("mid_rst_sel", 32'(disp_sel), 32'h0);
        chk("mid_rst_frozen", 32'(disp_frozen), 32'h0);
        chk("mid_rst_stale", 32'(disp_stale), 32'h0);
        reset = 1'b0;
        tick(3);
        chk("post_rst_frozen", 32'(disp_frozen), 32'h0);
        chk("post_rst_live", 32'(disp_data), 32'h00A0_0000);
`else
        press(1'b0, 1'b1);
        chk("nofrz_frozen", 32'(disp_frozen), 32'd0);
        chk("nofrz_sel", 32'(disp_sel), 32'd2);
        set_data(32'h0012_3456, 1'b0);
        tick(2);
        chk("nofrz_live", 32'(disp_data), 32'h0012_3456);
        press(1'b1, 1'b1);
        chk("nofrz_both_sel", 32'(disp_sel), 32'd3);
        chk("nofrz_both_frozen", 32'(disp_frozen), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
